// File: rtl/fifo_mem_ctrl.sv
// Ready/valid first-word-fall-through FIFO controller wrapped around a
// two-port memory with one-cycle read latency, plus a 2-entry output buffer.
module fifo_mem_ctrl #(
  parameter int addresses = 32,
  parameter int width = 8,
  localparam int addressWidth = (addresses > 1) ? $clog2(addresses) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inValid,
  output logic                    inReady,
  input  logic [width-1:0]        inData,
  output logic                    outValid,
  input  logic                    outReady,
  output logic [width-1:0]        outData,
  output logic [addressWidth+1:0] count,
  output logic [addressWidth-1:0] memWriteAddress,
  output logic                    memWriteEnable,
  output logic [width-1:0]        memWriteData,
  output logic [addressWidth-1:0] memReadAddress,
  output logic                    memReadEnable,
  input  logic [width-1:0]        memReadData
);

  localparam logic [addressWidth:0]   depth    = (addressWidth+1)'(addresses);
  localparam logic [addressWidth-1:0] lastAddr = addressWidth'(addresses - 1);

  logic [addressWidth-1:0] wrPtr;
  logic [addressWidth-1:0] rdPtr;
  logic [addressWidth:0]   memCount;
  logic                    readPending;
  logic [width-1:0]        outBuf [2];
  logic [1:0]              bufCount;
  logic                    accept;
  logic                    pop;
  logic                    issue;
  logic [1:0]              inFlight;
  logic [width-1:0]        nextBuf [2];
  logic [1:0]              nextBufCount;

  assign inReady  = !reset && (memCount < depth);
  assign accept   = inValid && inReady;
  assign outValid = (bufCount != 2'd0);
  assign outData  = outBuf[0];
  assign pop      = outValid && outReady;

  // Only prefetch when the returning word is guaranteed a buffer slot.
  assign inFlight = bufCount + {1'b0, readPending} - {1'b0, pop};
  assign issue    = (memCount != '0) && (inFlight < 2'd2);

  assign memWriteEnable  = accept;
  assign memWriteAddress = wrPtr;
  assign memWriteData    = accept ? inData : '0;
  assign memReadEnable   = issue;
  assign memReadAddress  = rdPtr;

  assign count = (addressWidth+2)'(memCount) + (addressWidth+2)'(readPending)
               + (addressWidth+2)'(bufCount);

  // A pop shifts the buffer first, so the returning word lands behind
  // whatever is still held.
  always_comb begin
    nextBuf      = outBuf;
    nextBufCount = bufCount;
    if (pop) begin
      nextBuf[0]   = outBuf[1];
      nextBufCount = bufCount - 2'd1;
    end
    if (readPending) begin
      nextBuf[nextBufCount[0]] = memReadData;
      nextBufCount             = nextBufCount + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      memCount    <= '0;
      readPending <= 1'b0;
      bufCount    <= '0;
      outBuf[0]   <= '0;
      outBuf[1]   <= '0;
    end else begin
      if (accept) begin
        wrPtr <= (wrPtr == lastAddr) ? '0 : wrPtr + addressWidth'(1);
      end
      if (issue) begin
        rdPtr <= (rdPtr == lastAddr) ? '0 : rdPtr + addressWidth'(1);
      end
      memCount    <= memCount + (addressWidth+1)'(accept) - (addressWidth+1)'(issue);
      readPending <= issue;
      bufCount    <= nextBufCount;
      outBuf      <= nextBuf;
    end
  end

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Directed bench for fifo_mem_ctrl with a behavioural two-port memory and a
// queue model of the FIFO contents.
module tb_fifo_mem_ctrl;

  logic       clk;
  logic       reset;
  logic       inValid;
  logic       inReady;
  logic [7:0] inData;
  logic       outValid;
  logic       outReady;
  logic [7:0] outData;
  logic [6:0] count;
  logic [4:0] memWriteAddress;
  logic       memWriteEnable;
  logic [7:0] memWriteData;
  logic [4:0] memReadAddress;
  logic       memReadEnable;
  logic [7:0] memReadData;

  logic [7:0] mem [32];
  logic [7:0] model [$];
  int compared = 0;
  int mismatched = 0;
  int acceptCount;
  int popCount;
  int wraps;
  int maxCount;
  int expWrAddr;
  int expRdAddr;

  fifo_mem_ctrl #(.addresses(32), .width(8)) dut (
    .clk(clk),
    .reset(reset),
    .inValid(inValid),
    .inReady(inReady),
    .inData(inData),
    .outValid(outValid),
    .outReady(outReady),
    .outData(outData),
    .count(count),
    .memWriteAddress(memWriteAddress),
    .memWriteEnable(memWriteEnable),
    .memWriteData(memWriteData),
    .memReadAddress(memReadAddress),
    .memReadEnable(memReadEnable),
    .memReadData(memReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory with registered read data, as the controller expects.
  always @(posedge clk) begin
    if (memWriteEnable) mem[memWriteAddress] <= memWriteData;
    if (memReadEnable) memReadData <= mem[memReadAddress];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r);
    inValid  = v;
    inData   = d;
    outReady = r;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".inReady"}, inReady, 0);
    checkOutput({tag, ".outValid"}, outValid, 0);
    checkOutput({tag, ".outData"}, outData, 0);
    checkOutput({tag, ".count"}, count, 0);
    checkOutput({tag, ".memWriteEnable"}, memWriteEnable, 0);
    checkOutput({tag, ".memReadEnable"}, memReadEnable, 0);
    checkOutput({tag, ".memWriteAddress"}, memWriteAddress, 0);
    checkOutput({tag, ".memReadAddress"}, memReadAddress, 0);
  endtask

  task automatic clearModel();
    model.delete();
    acceptCount = 0;
    popCount    = 0;
    wraps       = 0;
    maxCount    = 0;
    expWrAddr   = 0;
    expRdAddr   = 0;
  endtask

  task automatic resetDut();
    applyStimulus(1'b0, 8'h00, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    reset = 1'b0;
    clearModel();
    #1;
    checkOutput("releaseInReady", inReady, 1);
  endtask

  // One clock: drive, sample mid-cycle against the model, then check count after the edge.
  task automatic doCycle(input logic v, input logic [7:0] d, input logic r);
    logic accepted;
    logic popped;
    logic [7:0] exp;
    applyStimulus(v, d, r);
    #1;
    accepted = inValid && inReady;
    popped   = outValid && outReady;
    if (model.size() < 32) checkOutput("inReady", inReady, 1);
    if (model.size() >= 34) checkOutput("fullInReady", inReady, 0);
    if (model.size() == 0) begin
      checkOutput("validEmpty", outValid, 0);
    end else if (popped) begin
      exp = model.pop_front();
      checkOutput("outData", outData, exp);
      popCount++;
    end
    if (accepted) begin
      model.push_back(d);
      checkOutput("wrAddr", memWriteAddress, expWrAddr);
      checkOutput("wrData", memWriteData, d);
      if (expWrAddr == 31) wraps++;
      expWrAddr = (expWrAddr + 1) % 32;
      acceptCount++;
    end
    if (memReadEnable) begin
      checkOutput("rdAddr", memReadAddress, expRdAddr);
      expRdAddr = (expRdAddr + 1) % 32;
    end
    @(posedge clk);
    #1;
    checkOutput("count", count, 32'(model.size()));
    if (int'(count) > maxCount) maxCount = int'(count);
  endtask

  initial begin
    int firstReject;
    int pushed;
    int guard;
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    clearModel();
    #2;
    checkResetValues("asyncReset");

    // Fill with outReady low: 32 in memory plus 2 prefetched.
    resetDut();
    firstReject = -1;
    for (int i = 0; i < 40; i++) begin
      doCycle(1'b1, 8'(acceptCount), 1'b0);
      if (firstReject < 0 && acceptCount == i) firstReject = i;
    end
    checkOutput("fillAccepts", acceptCount, 34);
    checkOutput("fillFirstReject", firstReject, 34);
    checkOutput("fillCount", count, 34);

    // Drain at one word per cycle.
    popCount = 0;
    for (int i = 0; i < 34; i++) doCycle(1'b0, 8'h00, 1'b1);
    checkOutput("drainPops", popCount, 34);
    checkOutput("drainValid", outValid, 0);
    checkOutput("drainCount", count, 0);

    // Fall-through latency of three cycles.
    resetDut();
    doCycle(1'b1, 8'hA5, 1'b0);
    checkOutput("lat1Valid", outValid, 0);
    doCycle(1'b0, 8'h00, 1'b0);
    checkOutput("lat2Valid", outValid, 0);
    doCycle(1'b0, 8'h00, 1'b0);
    checkOutput("lat3Valid", outValid, 1);
    checkOutput("lat3Data", outData, 8'hA5);
    doCycle(1'b0, 8'h00, 1'b1);

    // Streaming 100 words with continuous pop.
    resetDut();
    pushed = 0;
    for (int i = 0; i < 110; i++) begin
      doCycle(pushed < 100, 8'(pushed), 1'b1);
      pushed = acceptCount;
    end
    checkOutput("streamPops", popCount, 100);
    checkOutput("streamWraps", wraps, 3);
    checkOutput("streamMaxCount", maxCount <= 3, 1);

    // Random traffic against the model.
    resetDut();
    for (int i = 0; i < 1000; i++) begin
      doCycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    guard = 0;
    while (model.size() != 0 && guard < 100) begin
      doCycle(1'b0, 8'h00, 1'b1);
      guard++;
    end
    checkOutput("randomDrained", model.size(), 0);
    checkOutput("randomBalance", popCount, acceptCount);

    // Reset in the middle of a stream.
    resetDut();
    for (int i = 0; i < 10; i++) doCycle(1'b1, 8'(i + 16), 1'b0);
    checkOutput("midCount", count, 10);
    applyStimulus(1'b1, 8'h33, 1'b1);
    reset = 1'b1;
    #2;
    checkResetValues("midReset");
    @(posedge clk);
    #1;
    checkResetValues("midResetHeld");
    reset = 1'b0;
    clearModel();
    doCycle(1'b1, 8'h5A, 1'b1);
    for (int i = 0; i < 8; i++) doCycle(1'b0, 8'h00, 1'b1);
    checkOutput("postResetPops", popCount, 1);
    checkOutput("postResetCount", count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fifo_mem_ctrl.md
# fifo_mem_ctrl

Synchronous FIFO controller that drives the write and read ports of a `twoPortMem` instance and turns it into a ready/valid first-word-fall-through FIFO. It sits directly in front of and behind the memory. Its write-side outputs feed the memory's write port, and it consumes the memory's one-cycle-latency `readData` into a 2-entry output buffer. Both memory clocks are tied to this block's `clk`.

## Interface
- `addresses`, 32, memory depth in entries (any value ≥ 2; not required to be a power of two)
- `width`, 8, data width in bits
- `addressWidth`, clogb2(addresses), localparam, not user-set

- `clk`  in  1  single clock for this block and both memory ports
- `reset`  in  1  asynchronous, active-high reset
- `inValid`  in  1  upstream has a word on `inData`
- `inReady`  out  1  FIFO accepts the word this cycle
- `inData`  in  width  write data
- `outValid`  out  1  `outData` holds the oldest word
- `outReady`  in  1  downstream takes `outData` this cycle
- `outData`  out  width  head-of-FIFO data
- `count`  out  addressWidth+2  total occupancy (memory + in-flight read + buffer), 0..addresses+2
- `memWriteAddress`  out  addressWidth  to memory `writeAddress`
- `memWriteEnable`  out  1  to memory `writeEnable`
- `memWriteData`  out  width  to memory `writeData`
- `memReadAddress`  out  addressWidth  to memory `readAddress`
- `memReadEnable`  out  1  to memory `readEnable`
- `memReadData`  in  width  from memory `readData`, valid the cycle after the `memReadEnable` edge

## Operation
- State:
  - `wrPtr` and `rdPtr` (addressWidth each)
  - `memCount` (0..addresses), the number of words written but not yet read from memory
  - `readPending` (1 bit)
  - 2-entry output buffer `buf[0..1]` with `bufCount` (0..2); `buf[0]` is the head
- Write side:
  - `inReady = !reset && memCount < addresses`.
  - Accept = `inValid && inReady`. On accept: `memWriteEnable=1`, `memWriteAddress=wrPtr`, `memWriteData=inData` (all combinational).
  - `wrPtr` advances at the edge; it wraps from addresses-1 to 0.
- Read issue: `memReadEnable = memCount>0 && (bufCount + readPending - pop) < 2`, where `pop = outValid && outReady`.
  - `memReadAddress = rdPtr`.
  - On issue, `rdPtr` advances with the same wrap rule, and `readPending` is 1 at the next edge, otherwise 0.
- Return:
  - When `readPending`=1, `memReadData` is written at the edge into the first free buffer slot.
  - The free-slot calculation accounts for a same-cycle pop, which shifts `buf[1]` into `buf[0]`.
- Output:
  - `outValid = bufCount>0`, `outData = buf[0]`.
  - `buf[0]` is held stable while `outValid && !outReady`.
- `memCount` next value = `memCount + accept − issue`. Simultaneous accept and issue leaves it unchanged.
- Full memory (`memCount==addresses`): no write is accepted, even when a read issues in the same cycle. As a result `wrPtr==rdPtr` never coincides with a write and a read to the same address.
- `count = memCount + readPending + bufCount`.
- Reset (asynchronous, any time, including mid-transfer):
  - Pointers, counts, `readPending` and the buffer are cleared.
  - Memory contents are abandoned.
  - Outputs during and after reset: `inReady=0` during reset and 1 after release; `outValid=0`, `outData=0`, `count=0`, `memWriteEnable=0`, `memReadEnable=0`; both addresses 0.

## Timing
- Fall-through latency: a word accepted in cycle 0 is written at edge E1. The read issues in cycle 1 and is captured into the buffer at E3. `outValid=1` in cycle 3.
- Sustained throughput: 1 word/cycle in and out simultaneously once the buffer is primed.
- `inReady` and `memReadEnable` are combinational from registered state plus `outReady`. There is no combinational path from `inValid` to `inReady`.
- `count` updates one edge after the causing event.

## Test plan
1. Reset, then push 0x00..0x1F (32 words) with `outReady=0`:
   - the first 32 cycles accept;
   - two reads prefetch and the buffer fills, so `inReady` stays high for 2 more accepts;
   - then `inReady=0` with `count=34`.
2. From that state, hold `outReady=1`: `outData` yields 0x00..0x21 in order, one per cycle, then `outValid=0` and `count=0`.
3. Single word 0xA5 into an empty FIFO: `outValid` rises exactly 3 cycles after the accept cycle with `outData=0xA5`.
4. Continuous push and pop with `outReady=1` for 100 words (data = index mod 256): no drops or duplicates, `count` stays ≤3, and the pointers wrap 3 times past address 31→0.
5. Random `inValid`/`outReady` (50%) for 1000 cycles against a scoreboard model: data order matches and `count` matches the model every cycle.
6. Assert `reset` mid-stream with `count=10`: at the next sample during reset, all outputs are at their reset values. After release, push 0x5A: `outData=0x5A` arrives with no stale words ahead of it.
